// File: rtl/key_pkg.sv
// Shared types and defaults for the key input conditioner.
// The debounce state encoding is common to every key channel.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/key_debouncer.sv
// One push-button channel: synchronizer, debounce FSM and a registered press pulse.
// The raw key is active-low; pressed_o and press_pulse_o are active-high.
//
// state        | meaning
// RELEASED     | key stable released, waiting for a pressed sample
// PRESS_WAIT   | counting consecutive pressed samples
// PRESSED      | key stable pressed, pulse already issued
// RELEASE_WAIT | counting consecutive released samples
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed_sync;
    key_state_t             state_q;
    key_state_t             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   pulse_q;
    logic                   pulse_d;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
        end
    end

    assign pressed_sync = ~sync_q[SYNC_STAGES-1];
    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (pressed_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!pressed_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressed_o     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign press_pulse_o = pulse_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Input stage for the B-register path: debounces KEY[1:0] into load/clear pulses and
// captures the synchronized B switches, so the datapath runs on clk instead of a key.
module key_input_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int B_WIDTH         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         key_n_i,
    input  logic [B_WIDTH-1:0] sw_b_i,
    output logic [B_WIDTH-1:0] b_q_o,
    output logic               load_pulse_o,
    output logic               clear_pulse_o,
    output logic [1:0]         key_pressed_o
);

    logic [B_WIDTH-1:0] sw_sync_q [SYNC_STAGES];
    logic [B_WIDTH-1:0] sw_last_q;
    logic [B_WIDTH-1:0] b_hold_q;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_key_load (
        .clk          (clk),
        .rst          (rst),
        .key_n_i      (key_n_i[0]),
        .pressed_o    (key_pressed_o[0]),
        .press_pulse_o(load_pulse_o)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_key_clear (
        .clk          (clk),
        .rst          (rst),
        .key_n_i      (key_n_i[1]),
        .pressed_o    (key_pressed_o[1]),
        .press_pulse_o(clear_pulse_o)
    );

    // sw_last_q trails the synchronizer by one flop so that, in the pulse cycle, it
    // holds the switch sample taken alongside the key sample that completed the debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync_q[s] <= '0;
            end
            sw_last_q <= '0;
            b_hold_q  <= '0;
        end else begin
            sw_sync_q[0] <= sw_b_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync_q[s] <= sw_sync_q[s-1];
            end
            sw_last_q <= sw_sync_q[SYNC_STAGES-1];
            b_hold_q  <= b_q_o;
        end
    end

    // Output is selected from flops only, so b_q_o changes on the same edge as the pulses.
    always_comb begin
        b_q_o = b_hold_q;
        if (clear_pulse_o) begin
            b_q_o = '0;
        end else if (load_pulse_o) begin
            b_q_o = sw_last_q;
        end
    end

endmodule
